// File: rtl/fifo_share_if.sv
// Bundle between the shared-FIFO controller and its requesters, consumer and fifo instance.
// The slave modport is the controller's view; master is everything around it.
`timescale 1ns/1ps
interface fifo_share_if #(
   parameter int N = 8,
   parameter int D = 4,
   parameter int R = 4
);
   logic [R-1:0]   req_valid;
   logic [R*N-1:0] req_data;
   logic [R-1:0]   req_ready;
   logic           fifo_wr;
   logic [N-1:0]   fifo_wr_data;
   logic           fifo_rd;
   logic [N-1:0]   fifo_rd_data;
   logic           cons_valid;
   logic           cons_ready;
   logic [N-1:0]   cons_data;
   logic [D:0]     count;
   logic           full;
   logic           empty;
   logic           almost_full;

   modport slave (
      input  req_valid, req_data, fifo_rd_data, cons_ready,
      output req_ready, fifo_wr, fifo_wr_data, fifo_rd,
             cons_valid, cons_data, count, full, empty, almost_full
   );

   modport master (
      output req_valid, req_data, fifo_rd_data, cons_ready,
      input  req_ready, fifo_wr, fifo_wr_data, fifo_rd,
             cons_valid, cons_data, count, full, empty, almost_full
   );
endinterface

// File: rtl/fifo_share_ctrl.sv
// Round-robin write arbiter and valid/ready read front end for one show-ahead fifo.
// Occupancy is tracked here because the fifo itself has no full/empty flags.
`timescale 1ns/1ps
module fifo_share_ctrl #(
   parameter int N  = 8,
   parameter int D  = 4,
   parameter int R  = 4,
   parameter int AF = 2**D - 2
) (
   input  logic          clk,
   input  logic          reset_n,
   fifo_share_if.slave   bus
);
   localparam int DEPTH = 2**D;
   localparam int LW    = (R > 1) ? $clog2(R) : 1;

   localparam logic [D:0]    CNT_FULL = (D+1)'(DEPTH);
   localparam logic [D:0]    CNT_AF   = (D+1)'(AF);
   localparam logic [D:0]    CNT_ONE  = (D+1)'(1);
   localparam logic [LW-1:0] LAST_RST = LW'(R-1);

   logic [D:0]    count_q;
   logic [LW-1:0] last_q;

   logic          wr_ok;
   logic          sel_any;
   logic [LW-1:0] sel_idx;
   logic [R-1:0]  grant;
   logic [N-1:0]  wr_data;
   logic          wr_fire;
   logic          rd_fire;
   logic          have_data;
   int            cand;

   // reset_n gates the grant so nothing reaches the fifo while it is being cleared
   assign wr_ok     = reset_n && (count_q != CNT_FULL);
   assign have_data = (count_q != '0);

   always_comb begin
      sel_any = 1'b0;
      sel_idx = last_q;
      cand    = 0;
      for (int k = 1; k <= R; k++) begin
         cand = (int'(last_q) + k) % R;
         if (!sel_any && bus.req_valid[cand[LW-1:0]]) begin
            sel_any = 1'b1;
            sel_idx = cand[LW-1:0];
         end
      end
   end

   always_comb begin
      grant = '0;
      if (sel_any && wr_ok) begin
         grant[sel_idx] = 1'b1;
      end
   end

   always_comb begin
      wr_data = '0;
      for (int i = 0; i < R; i++) begin
         if (grant[i]) begin
            wr_data = bus.req_data[i*N +: N];
         end
      end
   end

   assign wr_fire = |(bus.req_valid & grant);
   assign rd_fire = reset_n && have_data && bus.cons_ready;

   assign bus.req_ready    = grant;
   assign bus.fifo_wr      = wr_fire;
   assign bus.fifo_wr_data = wr_data;
   assign bus.fifo_rd      = rd_fire;
   assign bus.cons_valid   = have_data;
   assign bus.cons_data    = bus.fifo_rd_data;
   assign bus.count        = count_q;
   assign bus.full         = (count_q == CNT_FULL);
   assign bus.empty        = (count_q == '0);
   assign bus.almost_full  = (count_q >= CNT_AF);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         last_q  <= LAST_RST;
      end else begin
         case ({wr_fire, rd_fire})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
         if (wr_fire) begin
            last_q <= sel_idx;
         end
      end
   end
endmodule
